// File: rtl/pool_unit.sv
// Pipelined neighbourhood pooling unit: reduces NH_SIZE signed elements per beat
// to one value (mean-truncate, mean-round, max or min) through a registered pairwise tree.
module pool_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NH_SIZE    = 4,
  parameter int unsigned LOG2_NH    = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NH_SIZE*DATA_WIDTH-1:0] nh_vector,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         pool_out,
  output logic [CNT_WIDTH-1:0]          out_count
);

  // Uniform tree node width: wide enough for the full neighbourhood sum.
  localparam int unsigned SW    = DATA_WIDTH + LOG2_NH;
  localparam int unsigned NODES = NH_SIZE - 1;
  localparam logic signed [SW-1:0] RND = SW'(NH_SIZE / 2);

  logic                 advance;
  logic                 accept;
  logic signed [SW-1:0] tree_q [NODES];
  logic signed [SW-1:0] tree_d [NODES];
  logic [LOG2_NH-1:0]   valid_q;
  logic [1:0]           mode_q [LOG2_NH];
  logic [DATA_WIDTH-1:0] pool_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Index of the first node of tree stage k inside the flattened node array.
  function automatic int stage_off(input int k);
    return int'(NH_SIZE) - int'(NH_SIZE >> k);
  endfunction

  function automatic logic signed [SW-1:0] reduce(input logic signed [SW-1:0] a,
                                                  input logic signed [SW-1:0] b,
                                                  input logic [1:0]           m);
    logic signed [SW-1:0] r;
    r = a + b;
    if (m == 2'b10) r = (a > b) ? a : b;
    if (m == 2'b11) r = (a < b) ? a : b;
    return r;
  endfunction

  // Pairwise reduction of element 2j with 2j+1 at every stage; the mode travels with the beat.
  always_comb begin : tree_comb
    logic signed [SW-1:0] a;
    logic signed [SW-1:0] b;
    tree_d = tree_q;
    a = '0;
    b = '0;
    for (int j = 0; j < int'(NH_SIZE / 2); j++) begin
      a = SW'($signed(nh_vector[(2*j)*DATA_WIDTH +: DATA_WIDTH]));
      b = SW'($signed(nh_vector[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]));
      tree_d[j] = reduce(a, b, in_mode);
    end
    for (int k = 1; k < int'(LOG2_NH); k++) begin
      for (int j = 0; j < int'(NH_SIZE >> (k + 1)); j++) begin
        a = tree_q[stage_off(k - 1) + 2*j];
        b = tree_q[stage_off(k - 1) + 2*j + 1];
        tree_d[stage_off(k) + j] = reduce(a, b, mode_q[k-1]);
      end
    end
  end

  // Output stage: mean modes divide the full sum, max/min pass the tree value through.
  always_comb begin : out_comb
    pool_d = '0;
    case (mode_q[LOG2_NH-1])
      2'b00:   pool_d = DATA_WIDTH'(tree_q[NODES-1] >>> LOG2_NH);
      2'b01:   pool_d = DATA_WIDTH'((tree_q[NODES-1] + RND) >>> LOG2_NH);
      default: pool_d = DATA_WIDTH'(tree_q[NODES-1]);
    endcase
  end

  // Whole pipeline shifts together only when the output can move.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NODES); i++) tree_q[i] <= '0;
      for (int k = 0; k < int'(LOG2_NH); k++) mode_q[k] <= '0;
      valid_q   <= '0;
      out_valid <= 1'b0;
      pool_out  <= '0;
    end else if (advance) begin
      tree_q     <= tree_d;
      mode_q[0]  <= in_mode;
      valid_q[0] <= accept;
      for (int k = 1; k < int'(LOG2_NH); k++) begin
        mode_q[k]  <= mode_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      out_valid <= valid_q[LOG2_NH-1];
      pool_out  <= pool_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pool_unit.sv
// Randomised bench for pool_unit: an arithmetic reference model feeds a scoreboard
// queue; directed beats cover the arithmetic corners, backpressure and mid-stream reset.
module tb_pool_unit;

  localparam int DW = 8;
  localparam int NH = 4;
  localparam int LG = 2;
  localparam int CW = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [NH*DW-1:0]   nh_vector = '0;
  logic [1:0]         in_mode = 2'b00;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [DW-1:0]      pool_out;
  logic [CW-1:0]      out_count;

  pool_unit #(.DATA_WIDTH(DW), .NH_SIZE(NH), .LOG2_NH(LG), .CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .nh_vector (nh_vector),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pool_out  (pool_out),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] val;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   model_cnt = 0;
  bit   chk_lat   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [DW-1:0] ref_pool(input logic [NH*DW-1:0] v, input logic [1:0] m);
    int e;
    int s;
    int mx;
    int mn;
    int r;
    s  = 0;
    mx = -1000;
    mn = 1000;
    for (int i = 0; i < NH; i++) begin
      e = int'($signed(v[i*DW +: DW]));
      s = s + e;
      if (e > mx) mx = e;
      if (e < mn) mn = e;
    end
    case (m)
      2'd0:    r = floor_div(s, NH);
      2'd1:    r = floor_div(s + NH / 2, NH);
      2'd2:    r = mx;
      default: r = mn;
    endcase
    return r[DW-1:0];
  endfunction

  function automatic logic [NH*DW-1:0] pack(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // One clock: score the handshakes about to happen, then step past the edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pool_out", 32'(pool_out), 32'(e.val));
        if (chk_lat) check("latency", 32'(cyc - e.acc), 32'd3);
      end
      model_cnt++;
    end
    if (in_valid && in_ready) begin
      e.val = ref_pool(nh_vector, in_mode);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_pool_out", 32'(pool_out), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    in_valid  = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic single(input logic [NH*DW-1:0] v, input logic [1:0] m, input logic [DW-1:0] expv);
    int lat;
    nh_vector = v;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
    nh_vector = $urandom;
    in_mode   = 2'($urandom);
    lat = 1;
    while (!out_valid && lat < 8) begin
      cycle();
      lat++;
    end
    check("single_latency", 32'(lat), 32'd3);
    check("single_value", 32'(pool_out), 32'(expv));
    cycle();
  endtask

  initial begin
    int n;
    logic [DW-1:0] hold;

    do_reset();
    chk_lat = 1'b1;

    // Arithmetic corners: positive/negative means, no-overflow rounding, max/min extremes.
    single(pack(1, 2, 3, 5), 2'b00, 8'd2);
    single(pack(1, 2, 3, 5), 2'b01, 8'd3);
    single(pack(-1, -1, -1, -2), 2'b00, 8'hFE);
    single(pack(-1, -1, -1, -2), 2'b01, 8'hFF);
    single(pack(127, 127, 127, 127), 2'b01, 8'd127);
    single(pack(-128, 127, 0, 5), 2'b10, 8'd127);
    single(pack(-128, 127, 0, 5), 2'b11, 8'h80);
    single(pack(-3, -3, -3, -3), 2'b10, 8'hFD);
    check("directed_count", 32'(out_count), 32'(model_cnt));

    // Back-to-back beats with per-beat modes.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      nh_vector = $urandom;
      in_mode   = 2'(i % 4);
      cycle();
    end
    in_valid = 1'b0;
    repeat (5) cycle();
    check("stream_count", 32'(out_count), 32'd6);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Fill under backpressure, hold, then random traffic.
    do_reset();
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n = 0;
    while (in_ready && n < 10) begin
      nh_vector = $urandom;
      in_mode   = 2'($urandom);
      cycle();
      n++;
    end
    check("fill_depth", 32'(n), 32'd3);
    hold = pool_out;
    repeat (4) begin
      cycle();
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_pool_out", 32'(pool_out), 32'(hold));
    end
    out_ready = 1'b1;
    repeat (300) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      nh_vector = $urandom;
      in_mode   = 2'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) cycle();
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_count", 32'(out_count), 32'(model_cnt));

    // Mid-stream reset discards in-flight beats.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      nh_vector = $urandom;
      in_mode   = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    do_reset();
    chk_lat = 1'b1;
    single(pack(4, 4, 4, 4), 2'b00, 8'd4);
    repeat (6) cycle();
    check("post_reset_count", 32'(out_count), 32'd1);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
